// File: rtl/countdown_pkg.sv
// Shared types and sizing helpers for the countdown timer and its prescaler.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Prescaler counter width: enough bits for PRESCALE-1, never narrower than 1.
  function automatic int presc_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// With PRESCALE==1 the counter is constant zero and tick reduces to enable.
module countdown_tick_gen
  import countdown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic          w_wrap;

  assign w_wrap = (r_presc == LAST);
  assign tick   = enable && w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (clear) begin
      r_presc <= '0;
    end else if (enable) begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter/timer with prescaled ticks and a one-cycle done pulse.
// Optional periodic mode enabled by defining COUNTDOWN_AUTORELOAD_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_run;
  logic             w_tick;
  logic             w_load_zero;
  logic             w_last;

  assign w_run       = (r_state == ST_RUN);
  assign w_load_zero = (load_val == '0);
  // count<=1 rather than ==1 so a stray zero can never decrement into all-ones
  assign w_last      = w_tick && (r_count <= ONE);

  countdown_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (!w_run || abort),
    .enable(enable && w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = w_load_zero ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last && !AUTORELOAD) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Abort outranks the tick, and start is ignored while running.
  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = (w_state_nxt == ST_RUN);
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_count_nxt = load_val;
          w_done_nxt  = w_load_zero;
          if (!w_load_zero) begin
            w_reload_nxt = load_val;
          end
        end else begin
          w_count_nxt = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_count_nxt = '0;
        end else if (w_tick) begin
          if (w_last) begin
            w_count_nxt = AUTORELOAD ? r_reload : '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_count_nxt = r_count - ONE;
          end
        end
      end
      default: w_count_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
